// File: rtl/button_debounce.sv
// Two-button debouncer: 2-flop synchronizer plus qualification FSM per button,
// press pulses, optional long-press pulses when DEBOUNCE_LONGPRESS_EN is defined.

// state | meaning
// REL   | released, waiting for a low sample
// CHK_P | qualifying a press, counting stable low samples
// PRS   | pressed
// CHK_R | qualifying a release, counting stable high samples
module button_debounce_ch #(
  parameter int DEBOUNCE_CYCLES  = 270000,
  parameter int LONGPRESS_CYCLES = 27000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic long_pulse
);

  localparam int MAX_C = (LONGPRESS_CYCLES > DEBOUNCE_CYCLES) ? LONGPRESS_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] DEB_TC = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} state_t;

  state_t        st_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          s;

  assign s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= REL;
      cnt_q <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      case (st_q)
        REL: begin
          if (!s) begin
            st_q  <= CHK_P;
            cnt_q <= CW'(1);
          end
        end
        CHK_P: begin
          if (s) begin
            st_q  <= REL;
            cnt_q <= '0;
          end else if (cnt_q == DEB_TC) begin
            st_q  <= PRS;
            cnt_q <= '0;
            level <= 1'b0;
            press <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PRS: begin
          if (s) begin
            st_q  <= CHK_R;
            cnt_q <= CW'(1);
          end
        end
        CHK_R: begin
          if (!s) begin
            st_q  <= PRS;
            cnt_q <= '0;
          end else if (cnt_q == DEB_TC) begin
            st_q  <= REL;
            cnt_q <= '0;
            level <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          st_q  <= REL;
          cnt_q <= '0;
          level <= 1'b1;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam logic [CW-1:0] LONG_TC  = CW'(LONGPRESS_CYCLES - 1);
  localparam logic [CW-1:0] LONG_PRE = CW'(LONGPRESS_CYCLES - 2);

  logic [CW-1:0] hold_q;

  // Hold counter saturates at its terminal count so each press yields one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      long_pulse <= 1'b0;
    end else if (st_q == PRS && !s) begin
      if (hold_q != LONG_TC) begin
        hold_q <= hold_q + CW'(1);
      end
      long_pulse <= (hold_q == LONG_PRE);
    end else begin
      hold_q     <= '0;
      long_pulse <= 1'b0;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

module button_debounce #(
  parameter int DEBOUNCE_CYCLES  = 270000,
  parameter int LONGPRESS_CYCLES = 27000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_0_raw,
  input  logic button_1_raw,
  output logic button_0,
  output logic button_1,
  output logic press_0,
  output logic press_1,
  output logic long_0,
  output logic long_1
);

  button_debounce_ch #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONGPRESS_CYCLES (LONGPRESS_CYCLES)
  ) u_ch0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (button_0_raw),
    .level      (button_0),
    .press      (press_0),
    .long_pulse (long_0)
  );

  button_debounce_ch #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONGPRESS_CYCLES (LONGPRESS_CYCLES)
  ) u_ch1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (button_1_raw),
    .level      (button_1),
    .press      (press_1),
    .long_pulse (long_1)
  );

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 270000 (10 ms at 27 MHz), number of consecutive stable synchronized samples needed to accept a level change; legal range >= 2.
REQ-002 SHALL have parameter LONGPRESS_CYCLES, default 27000000 (1 s at 27 MHz), held-pressed duration for long-press detection; legal range > DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk  input  1  single system clock; all flops rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port button_0_raw  input  1  raw pin, asynchronous, active-low (0 = pressed), bouncing.
REQ-006 SHALL have port button_1_raw  input  1  as button_0_raw, second button.
REQ-007 SHALL have port button_0  output  1  debounced level, active-low; drives the downstream LED control block's button_0 directly.
REQ-008 SHALL have port button_1  output  1  debounced level, active-low; drives downstream button_1.
REQ-009 SHALL have port press_0  output  1  one-cycle pulse, active-high, on accepted press of button 0.
REQ-010 SHALL have port press_1  output  1  as press_0, button 1.
REQ-011 SHALL have port long_0  output  1  one-cycle pulse, active-high, on long press of button 0.
REQ-012 SHALL have port long_1  output  1  as long_0, button 1.

Function
REQ-013 SHALL pass each raw input through a 2-flop synchronizer; only the second flop output (s) is used downstream.
REQ-014 SHALL implement one independent FSM per button, states REL (released), CHK_P (qualifying press), PRS (pressed), CHK_R (qualifying release).
REQ-015 REL: s=1 stay; s=0 -> CHK_P, count=1. PRS: s=0 stay; s=1 -> CHK_R, count=1.
REQ-016 CHK_P/CHK_R: s returns to the current accepted level -> back to REL/PRS, count=0; s holds new level and count=DEBOUNCE_CYCLES-1 -> PRS/REL, count=0; otherwise count+1.
REQ-017 button_N SHALL be 0 in PRS and CHK_R, 1 in REL and CHK_P; a clean raw edge sampled at edge k SHALL change button_N at edge k+DEBOUNCE_CYCLES+1.
REQ-018 press_N SHALL be 1 for exactly the cycle in which button_N first reads 0 (CHK_P -> PRS transition); no pulse on release.
REQ-019 Any bounce shorter than DEBOUNCE_CYCLES SHALL produce no output change and no pulse; the qualification count restarts from zero after each bounce.
REQ-020 Counter width SHALL be $clog2(max(DEBOUNCE_CYCLES,LONGPRESS_CYCLES)+1); counters SHALL never wrap.
REQ-021 Both buttons SHALL be fully independent; simultaneous qualification SHALL assert press_0 and press_1 in the same cycle.

Reset
REQ-022 rst_n=0 SHALL immediately force: synchronizer flops 1, FSMs REL, all counters 0, button_0=button_1=1, press_N=0, long_N=0.
REQ-023 Reset asserted mid-qualification or mid-press SHALL discard progress; after release, a held-low raw input SHALL be re-qualified from zero (no press pulse before a full DEBOUNCE_CYCLES run).

Configuration
REQ-024 Macro DEBOUNCE_LONGPRESS_EN defined: in PRS a hold counter SHALL increment each cycle from 0 at PRS entry; when it reaches LONGPRESS_CYCLES-1, long_N SHALL pulse one cycle, then the counter saturates (one pulse per press); leaving PRS clears it.
REQ-025 Macro undefined: hold counters SHALL not be built; long_0/long_1 SHALL remain present and tied to 0.

Verification (DEBOUNCE_CYCLES=8, LONGPRESS_CYCLES=20)
REQ-026 Reset: rst_n=0 with both raw=0 -> button_0=button_1=1, all pulses 0; release rst_n, keep raw=0 -> press_0 at edge 10 after release, not earlier.
REQ-027 Clean press: button_0_raw 1->0 sampled at edge 0 -> button_0=0 and press_0=1 at edge 9, press_0=0 at edge 10.
REQ-028 Bounce: raw_0 low 5 cycles, high 1, low 10 -> exactly one press_0, button_0 falls 8 cycles after final low run starts (+1 sync); release glitch of 3 cycles high -> button_0 stays 0.
REQ-029 Simultaneous: both raw fall same edge -> press_0 and press_1 assert same cycle; button_1 released alone -> button_0 unaffected.
REQ-030 Reset mid-qualification: raw_0 low 5 cycles, rst_n pulse, raw_0 held low -> no press_0 until a fresh 8-sample run completes.
REQ-031 Long press: with DEBOUNCE_LONGPRESS_EN, hold raw_0 low 40 cycles -> single long_0 pulse 19 cycles after press_0; without macro long_0 stays 0.
